// File: rtl/onehot_encoder83_stream.sv
// onehot_encoder83_stream
// Latches one request vector per input handshake and emits the binary index of
// every set bit, one index per output handshake. The default order is lowest
// index first. Defining ENC83_MSB_FIRST_EN emits the highest index first.
// An all-zero vector produces a single beat with out_zero=1, out_last=1, dout=0.
//
// state | meaning
// IDLE  | waiting for a vector, in_ready=1
// EMIT  | presenting indices from the pending register, out_valid=1
module onehot_encoder83_stream #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             out_zero
);

    typedef enum logic {IDLE, EMIT} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] dout_q, dout_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             out_zero_q, out_zero_d;

    // Index of the set bit to emit next; 0 when nothing is set.
    function automatic logic [IDX_W-1:0] scan_idx(input logic [WIDTH-1:0] p);
        logic [IDX_W-1:0] idx;
        idx = '0;
`ifdef ENC83_MSB_FIRST_EN
        for (int i = 0; i < WIDTH; i++) begin
            if (p[i]) idx = IDX_W'(i);
        end
`else
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (p[i]) idx = IDX_W'(i);
        end
`endif
        return idx;
    endfunction

    // Next state and pending bits, then the output registers decoded from them,
    // so every output is a flop and nothing combinational reaches a port.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pending_d = din;
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        pending_d = '0;
                        state_d   = IDLE;
                    end else begin
                        pending_d = pending_q & ~(WIDTH'(1) << dout_q);
                    end
                end
            end
            default: begin
                pending_d = '0;
                state_d   = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == EMIT);
        dout_d      = '0;
        out_last_d  = 1'b0;
        out_zero_d  = 1'b0;
        if (state_d == EMIT) begin
            dout_d     = scan_idx(pending_d);
            // A zero vector is its own (single, final) beat.
            out_zero_d = (pending_d == '0);
            out_last_d = (pending_d == '0) ||
                         ((pending_d & (pending_d - WIDTH'(1))) == '0);
        end
    end

    // State, pending vector and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            dout_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            dout_q      <= dout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign out_last  = out_last_q;
    assign out_zero  = out_zero_q;

endmodule
